branch_resolve: RTL

Control-flow resolution stage sitting directly downstream of the ALU comparator. It consumes the comparator's 32-bit result together with decoded branch/jump info. It decides taken/not-taken under a static not-taken policy, computes the target and link address, and issues a registered PC redirect. On a redirect it holds a multi-cycle front-end flush, squashing wrong-path instructions. It also keeps saturating branch statistics counters.

---
 rtl/branch_resolve.sv | 92 +++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: resolves branch/jump outcome, issues PC redirect with multi-cycle flush, keeps branch statistics
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_cmp_result,
  input  logic             i_clr_cnt,
  output logic             o_redirect,
  output logic [31:0]      o_target,
  output logic [31:0]      o_link,
  output logic             o_link_valid,
  output logic             o_flush,
  output logic             o_misalign,
  output logic [31:0]      o_bad_addr,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic acc, is_br, is_jump, taken, mis, go, link_go, br_inc, tk_inc;
  logic [31:0] tgt;
  logic unused_cmp;
  assign unused_cmp = ^i_cmp_result[31:1];
  assign acc = i_valid && state == IDLE;
  assign is_jump = i_is_jal || i_is_jalr;
  assign is_br = !is_jump && i_is_branch;
  assign taken = is_jump || (is_br && i_cmp_result[0]);
  assign tgt = i_is_jalr ? (i_rs1 + i_imm) & ~32'h1 : i_pc + i_imm;
  assign mis = acc && taken && tgt[1];
  assign go = acc && taken && !tgt[1];
  assign link_go = acc && is_jump && !tgt[1];
  assign br_inc = acc && is_br;
  assign tk_inc = br_inc && i_cmp_result[0];
  assign o_flush = state == FLUSH;
  // FSM state and flush countdown register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      fcnt <= '0;
    end else begin
      state <= state_nxt;
      fcnt <= fcnt_nxt;
    end
  end
  // enter FLUSH on an aligned taken redirect, leave once the countdown reaches zero
  always_comb begin
    state_nxt = state == IDLE ? (go ? FLUSH : IDLE) : (fcnt == '0 ? IDLE : FLUSH);
    fcnt_nxt = state == IDLE ? (go ? FW'(FLUSH_CYCLES - 1) : fcnt) : (fcnt == '0 ? fcnt : fcnt - FW'(1));
  end
  // registered redirect, link and misalign reporting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_redirect <= 1'b0;
      o_target <= '0;
      o_link <= '0;
      o_link_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_bad_addr <= '0;
    end else begin
      o_redirect <= go;
      o_link_valid <= link_go;
      o_misalign <= mis;
      if (go) o_target <= tgt;
      if (link_go) o_link <= i_pc + 32'd4;
      if (mis) o_bad_addr <= tgt;
    end
  end
  // saturating branch statistics, clear wins over a simultaneous increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_branch_cnt <= '0;
      o_taken_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_branch_cnt <= '0;
      o_taken_cnt <= '0;
    end else begin
      if (br_inc && !(&o_branch_cnt)) o_branch_cnt <= o_branch_cnt + 1'b1;
      if (tk_inc && !(&o_taken_cnt)) o_taken_cnt <= o_taken_cnt + 1'b1;
    end
  end
endmodule
